// File: rtl/key_conditioner.sv
// Multi-channel key conditioner: synchroniser, debounce, press/release pulses and optional auto-repeat per key.
// Level and press change SYNC_STAGES+DEBOUNCE_CYCLES-1 edges after the key is first sampled; no backpressure.
module key_conditioner #(
   parameter int N_KEYS          = 4,
   parameter bit KEY_ACTIVE_LOW  = 1'b1,
   parameter int SYNC_STAGES     = 2,
   parameter int DEBOUNCE_CYCLES = 50000,
   parameter int REPEAT_DELAY    = 25000000,
   parameter int REPEAT_PERIOD   = 5000000
) (
   input  logic              Clk,
   input  logic              Reset,
   input  logic [N_KEYS-1:0] key_in,
   input  logic [N_KEYS-1:0] repeat_en,
   output logic [N_KEYS-1:0] level_out,
   output logic [N_KEYS-1:0] press_pulse,
   output logic [N_KEYS-1:0] release_pulse
);

   localparam int DB_W    = $clog2(DEBOUNCE_CYCLES + 1);
   localparam int RPT_MAX = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
   localparam int RPT_W   = $clog2(RPT_MAX + 1);

   localparam logic [DB_W-1:0]   DB_LAST     = DB_W'(DEBOUNCE_CYCLES - 1);
   localparam logic [RPT_W-1:0]  DELAY_LAST  = RPT_W'(REPEAT_DELAY - 1);
   localparam logic [RPT_W-1:0]  PERIOD_LAST = RPT_W'(REPEAT_PERIOD - 1);
   localparam logic [N_KEYS-1:0] RELEASED_RAW = KEY_ACTIVE_LOW ? {N_KEYS{1'b1}} : {N_KEYS{1'b0}};

   typedef enum logic [1:0] {
      ST_UP     = 2'd0,
      ST_DELAY  = 2'd1,
      ST_REPEAT = 2'd2
   } state_t;

   logic [N_KEYS-1:0] sync_q [SYNC_STAGES];
   logic [N_KEYS-1:0] pressed_s;

   // Reset loads the released level so a key held through reset is seen as a fresh press.
   always_ff @(posedge Clk or negedge Reset) begin
      if (!Reset) begin
         for (int i = 0; i < SYNC_STAGES; i++) begin
            sync_q[i] <= RELEASED_RAW;
         end
      end else begin
         sync_q[0] <= key_in;
         for (int i = 1; i < SYNC_STAGES; i++) begin
            sync_q[i] <= sync_q[i-1];
         end
      end
   end

   assign pressed_s = KEY_ACTIVE_LOW ? ~sync_q[SYNC_STAGES-1] : sync_q[SYNC_STAGES-1];

   for (genvar ch = 0; ch < N_KEYS; ch++) begin : g_ch
      logic [DB_W-1:0]  cnt_q, cnt_d;
      logic [RPT_W-1:0] rpt_q, rpt_d;
      logic             lvl_q, lvl_d;
      logic             press_q, press_d;
      logic             rel_q, rel_d;
      logic             rise, fall;
      state_t           state_q, state_d;

      always_comb begin
         cnt_d   = cnt_q;
         lvl_d   = lvl_q;
         rpt_d   = rpt_q;
         state_d = state_q;
         press_d = 1'b0;
         rel_d   = 1'b0;

         if (pressed_s[ch] == lvl_q) begin
            cnt_d = '0;
         end else if (cnt_q == DB_LAST) begin
            lvl_d = ~lvl_q;
            cnt_d = '0;
         end else begin
            cnt_d = cnt_q + 1'b1;
         end

         // Pulses are registered alongside the level so they line up with its edge.
         rise = lvl_d & ~lvl_q;
         fall = ~lvl_d & lvl_q;

         case (state_q)
            ST_UP: begin
               if (rise) begin
                  press_d = 1'b1;
                  rpt_d   = '0;
                  state_d = ST_DELAY;
               end
            end
            ST_DELAY, ST_REPEAT: begin
               if (fall) begin
                  rel_d   = 1'b1;
                  rpt_d   = '0;
                  state_d = ST_UP;
               end else if (!repeat_en[ch]) begin
                  rpt_d = '0;
               end else if (rpt_q == ((state_q == ST_DELAY) ? DELAY_LAST : PERIOD_LAST)) begin
                  press_d = 1'b1;
                  rpt_d   = '0;
                  state_d = ST_REPEAT;
               end else begin
                  rpt_d = rpt_q + 1'b1;
               end
            end
            default: begin
               rpt_d   = '0;
               state_d = ST_UP;
            end
         endcase
      end

      always_ff @(posedge Clk or negedge Reset) begin
         if (!Reset) begin
            cnt_q   <= '0;
            rpt_q   <= '0;
            lvl_q   <= 1'b0;
            press_q <= 1'b0;
            rel_q   <= 1'b0;
            state_q <= ST_UP;
         end else begin
            cnt_q   <= cnt_d;
            rpt_q   <= rpt_d;
            lvl_q   <= lvl_d;
            press_q <= press_d;
            rel_q   <= rel_d;
            state_q <= state_d;
         end
      end

      assign level_out[ch]     = lvl_q;
      assign press_pulse[ch]   = press_q;
      assign release_pulse[ch] = rel_q;
   end

endmodule

// File: tb/tb_key_conditioner.sv
module tb_key_conditioner;
   localparam int NK = 2;
   localparam int DC = 4;
   localparam int RD = 10;
   localparam int RP = 3;

   logic          Clk = 1'b0;
   logic          Reset;
   logic [NK-1:0] key_in;
   logic [NK-1:0] repeat_en;
   logic [NK-1:0] level_out;
   logic [NK-1:0] press_pulse;
   logic [NK-1:0] release_pulse;

   key_conditioner #(
      .N_KEYS(NK), .KEY_ACTIVE_LOW(1'b1), .SYNC_STAGES(2),
      .DEBOUNCE_CYCLES(DC), .REPEAT_DELAY(RD), .REPEAT_PERIOD(RP)
   ) dut (
      .Clk(Clk), .Reset(Reset), .key_in(key_in), .repeat_en(repeat_en),
      .level_out(level_out), .press_pulse(press_pulse), .release_pulse(release_pulse)
   );

   always #5 Clk = ~Clk;

   int total = 0;
   int bad = 0;

   // Reference model: pressed samples in flight, run length of disagreement, repeat timing.
   bit [NK-1:0] samp_q[$];
   bit [NK-1:0] m_lvl, m_press, m_rel, m_held, m_first;
   int          m_run[NK];
   int          m_ctr[NK];

   int edge_n = 0;
   int mark = 0;
   int p0[$], p1[$], r0[$], r1[$];

   task automatic check_v(input string tag, input logic [NK-1:0] obs, input logic [NK-1:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
      end
   endtask

   task automatic check_i(input string tag, input int obs, input int exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
      end
   endtask

   task automatic check_q(input string tag, input int obs[$], input int exp[$]);
      check_i({tag, "_count"}, obs.size(), exp.size());
      for (int i = 0; i < obs.size() && i < exp.size(); i++)
         check_i($sformatf("%s_%0d", tag, i), obs[i], exp[i]);
   endtask

   task automatic model_reset();
      m_lvl = '0; m_press = '0; m_rel = '0; m_held = '0; m_first = '0;
      for (int ch = 0; ch < NK; ch++) begin
         m_run[ch] = 0;
         m_ctr[ch] = 0;
      end
      samp_q.delete();
      samp_q.push_back('0);
      samp_q.push_back('0);
   endtask

   task automatic model_edge();
      bit [NK-1:0] s;
      bit prev;
      int thr;
      s = samp_q.pop_front();
      samp_q.push_back(~key_in);
      m_press = '0;
      m_rel = '0;
      for (int ch = 0; ch < NK; ch++) begin
         prev = m_lvl[ch];
         if (s[ch] != m_lvl[ch]) begin
            m_run[ch]++;
            if (m_run[ch] == DC) begin
               m_lvl[ch] = ~m_lvl[ch];
               m_run[ch] = 0;
            end
         end else begin
            m_run[ch] = 0;
         end
         if (m_lvl[ch] && !prev) begin
            m_press[ch] = 1'b1; m_held[ch] = 1'b1; m_first[ch] = 1'b1; m_ctr[ch] = 0;
         end else if (!m_lvl[ch] && prev) begin
            m_rel[ch] = 1'b1; m_held[ch] = 1'b0;
         end else if (m_held[ch]) begin
            if (repeat_en[ch]) begin
               m_ctr[ch]++;
               thr = m_first[ch] ? RD : RP;
               if (m_ctr[ch] == thr) begin
                  m_press[ch] = 1'b1; m_ctr[ch] = 0; m_first[ch] = 1'b0;
               end
            end else begin
               m_ctr[ch] = 0;
            end
         end
      end
   endtask

   task automatic start_window();
      mark = edge_n;
      p0.delete(); p1.delete(); r0.delete(); r1.delete();
   endtask

   task automatic tick();
      int idx;
      @(posedge Clk);
      if (Reset) model_edge();
      else model_reset();
      idx = edge_n - mark;
      edge_n++;
      @(negedge Clk);
      check_v("level", level_out, m_lvl);
      check_v("press", press_pulse, m_press);
      check_v("release", release_pulse, m_rel);
      check_v("press_and_release", press_pulse & release_pulse, '0);
      if (press_pulse[0]) p0.push_back(idx);
      if (press_pulse[1]) p1.push_back(idx);
      if (release_pulse[0]) r0.push_back(idx);
      if (release_pulse[1]) r1.push_back(idx);
   endtask

   task automatic ticks(input int n);
      for (int i = 0; i < n; i++) tick();
   endtask

   initial begin
      #2000000;
      $display("FAIL watchdog observed=timeout expected=finish");
      $fatal(1, "watchdog");
   end

   initial begin
      bit hold_mode;
      // Reset with both keys held
      Reset = 1'b0; key_in = 2'b00; repeat_en = 2'b00;
      model_reset();
      #1;
      check_v("reset_level", level_out, 2'b00);
      check_v("reset_press", press_pulse, 2'b00);
      check_v("reset_release", release_pulse, 2'b00);
      ticks(3);
      @(negedge Clk);
      Reset = 1'b1;
      start_window();
      ticks(8);
      check_q("t1_press0", p0, '{5});
      check_q("t1_press1", p1, '{5});
      check_v("t1_level", level_out, 2'b11);

      key_in = 2'b11;
      ticks(8);
      check_v("released_level", level_out, 2'b00);

      // Clean press then release on ch0
      start_window();
      key_in[0] = 1'b0;
      ticks(8);
      check_q("t2_press0", p0, '{5});
      start_window();
      key_in[0] = 1'b1;
      ticks(8);
      check_q("t2_release0", r0, '{5});

      // Glitch of three cycles
      start_window();
      key_in[0] = 1'b0;
      ticks(3);
      key_in[0] = 1'b1;
      ticks(10);
      check_i("t3_press_cnt", p0.size(), 0);
      check_i("t3_release_cnt", r0.size(), 0);
      check_v("t3_level", level_out, 2'b00);

      // Auto-repeat enabled then disabled
      repeat_en = 2'b01;
      start_window();
      key_in[0] = 1'b0;
      ticks(22);
      check_q("t4_repeat_on", p0, '{5, 15, 18, 21});
      key_in[0] = 1'b1;
      ticks(8);
      repeat_en = 2'b00;
      start_window();
      key_in[0] = 1'b0;
      ticks(22);
      check_q("t4_repeat_off", p0, '{5});
      key_in[0] = 1'b1;
      ticks(8);

      // Simultaneous press, ch1 released while ch0 repeats
      repeat_en = 2'b01;
      start_window();
      key_in = 2'b00;
      ticks(20);
      key_in[1] = 1'b1;
      ticks(13);
      check_q("t5_press0", p0, '{5, 15, 18, 21, 24, 27, 30});
      check_q("t5_press1", p1, '{5});
      check_q("t5_release1", r1, '{25});
      check_i("t5_release0_cnt", r0.size(), 0);
      check_v("t5_level", level_out, 2'b01);

      // Reset pulse while ch0 is repeating
      Reset = 1'b0;
      #1;
      check_v("t6_async_level", level_out, 2'b00);
      check_v("t6_async_press", press_pulse, 2'b00);
      check_v("t6_async_release", release_pulse, 2'b00);
      model_reset();
      tick();
      Reset = 1'b1;
      start_window();
      ticks(8);
      check_q("t6_press0", p0, '{5});
      check_i("t6_release0_cnt", r0.size(), 0);
      check_i("t6_press1_cnt", p1.size(), 0);

      // Randomised traffic against the model
      hold_mode = 1'b0;
      for (int cyc = 0; cyc < 2500; cyc++) begin
         if (cyc % 200 == 0) hold_mode = ~hold_mode;
         for (int ch = 0; ch < NK; ch++) begin
            if ($urandom_range(0, hold_mode ? 30 : 3) == 0) key_in[ch] = ~key_in[ch];
            if ($urandom_range(0, 39) == 0) repeat_en[ch] = ~repeat_en[ch];
         end
         Reset = ($urandom_range(0, 399) != 0);
         if (!Reset) begin
            #1;
            check_v("rand_async_level", level_out, 2'b00);
         end
         tick();
      end
      Reset = 1'b1;
      ticks(2);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
